// File: rtl/dbg_trig_pkg.sv
// ---------------------------------------------------------------------------
// dbg_trig_pkg
// Shared types and defaults for the debug trigger sequencer.
//   trig_state_e : sequencer FSM states (2-bit encoding, also visible on o_state)
//   trig_mode_e  : source combine mode (ANY = OR of masked, ALL = AND of masked)
//   CTR_W_DEFAULT: default width of the holdoff / post / timeout counters
// ---------------------------------------------------------------------------
package dbg_trig_pkg;

    localparam int CTR_W_DEFAULT = 27;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDOFF = 2'd1,
        WAIT    = 2'd2,
        FIRE    = 2'd3
    } trig_state_e;

    typedef enum logic {
        ANY = 1'b0,
        ALL = 1'b1
    } trig_mode_e;

endpackage

// File: rtl/dbg_trig_cnt.sv
// ---------------------------------------------------------------------------
// dbg_trig_cnt
// Loadable down-counter used for the holdoff, post and timeout intervals.
// Load has priority over enable; the count parks at zero instead of wrapping,
// so a loaded value of zero never produces a 'last' flag.
//   clk   : system clock
//   rst   : synchronous active-high reset (count -> 0)
//   load  : load 'value' into the counter
//   en    : decrement by one (when not loading and count != 0)
//   value : load value
//   last  : count == 1
// ---------------------------------------------------------------------------
module dbg_trig_cnt #(
    parameter int CTR_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CTR_W-1:0] value,
    output logic             last
);

    logic [CTR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == CTR_W'(1));

endmodule

// File: rtl/dbg_trig_seq.sv
// ---------------------------------------------------------------------------
// dbg_trig_seq
// Programmable trigger sequencer for logic-analyzer capture.
// Arm -> holdoff delay -> wait for a masked source combination -> drive the
// capture trigger for a programmed number of cycles (or sticky when post=0).
//
// Optional feature: define DBG_TRIG_TIMEOUT_EN to add a WAIT-state timeout of
// TIMEOUT cycles that forces a fire with o_hit_src = 0. Without the macro the
// WAIT state holds indefinitely and no timeout counter exists.
//
// Ports:
//   i_clk       : system clock
//   i_rst       : synchronous active-high reset
//   i_arm       : single-cycle arm request (ignored while busy)
//   i_abort     : single-cycle abort request (wins over a same-cycle arm)
//   i_holdoff   : holdoff cycles after arm, latched at arm
//   i_post      : trigger high time in cycles, 0 = sticky, latched at arm
//   i_src       : trigger sources, synchronous to i_clk
//   i_src_mask  : 1 = source participates, latched at arm
//   i_mode      : 0 = ANY, 1 = ALL, latched at arm
//   o_trig      : registered capture trigger
//   o_busy      : state != IDLE (registered)
//   o_done      : one-cycle pulse on the first IDLE cycle after a timed fire
//   o_state     : current FSM state
//   o_hit_src   : masked sources latched at the hit cycle
//
// Handshake note: i_arm / i_abort are single-cycle strobes sampled on the
// rising edge; there is no backpressure. An arm is accepted only when the
// state is IDLE and no abort is present in the same cycle.
// ---------------------------------------------------------------------------
module dbg_trig_seq
    import dbg_trig_pkg::*;
#(
    parameter int CTR_W   = CTR_W_DEFAULT,
    parameter int N_SRC   = 4,
    parameter int TIMEOUT = 100000000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_arm,
    input  logic             i_abort,
    input  logic [CTR_W-1:0] i_holdoff,
    input  logic [CTR_W-1:0] i_post,
    input  logic [N_SRC-1:0] i_src,
    input  logic [N_SRC-1:0] i_src_mask,
    input  logic             i_mode,
    output logic             o_trig,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state,
    output logic [N_SRC-1:0] o_hit_src
);

    trig_state_e      state;
    trig_state_e      state_nx;

    // Shadow copies of the configuration taken at arm time
    logic [CTR_W-1:0] post_q;
    logic [N_SRC-1:0] mask_q;
    trig_mode_e       mode_q;

    logic             arm_take;
    logic             fire_take;
    logic             hit;
    logic             expire;
    logic             sticky;
    logic             hold_last;
    logic             post_last;

    logic             trig_nx;
    logic             done_nx;
    logic [N_SRC-1:0] hit_src_nx;

    assign arm_take  = (state == IDLE) && i_arm && !i_abort;
    assign fire_take = (state == WAIT) && (state_nx == FIRE);
    assign sticky    = (post_q == '0);

    // An empty mask turns the sequencer into a pure delayed trigger
    always_comb begin
        if (mask_q == '0) begin
            hit = 1'b1;
        end else if (mode_q == ALL) begin
            hit = &(i_src | ~mask_q);
        end else begin
            hit = |(i_src & mask_q);
        end
    end

    // Holdoff: loaded at arm; 'last' marks the final HOLDOFF cycle
    dbg_trig_cnt #(.CTR_W(CTR_W)) u_hold_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  (arm_take),
        .en    (state == HOLDOFF),
        .value (i_holdoff),
        .last  (hold_last)
    );

    // Post: loaded on the hit; a zero load never raises 'last' (sticky)
    dbg_trig_cnt #(.CTR_W(CTR_W)) u_post_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  (fire_take),
        .en    (state == FIRE),
        .value (post_q),
        .last  (post_last)
    );

`ifdef DBG_TRIG_TIMEOUT_EN
    logic to_last;

    // Loaded on WAIT entry so its last cycle is the TIMEOUT-th WAIT cycle
    dbg_trig_cnt #(.CTR_W(CTR_W)) u_to_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  ((state_nx == WAIT) && (state != WAIT)),
        .en    (state == WAIT),
        .value (CTR_W'(TIMEOUT)),
        .last  (to_last)
    );

    assign expire = (state == WAIT) && to_last;
`else
    assign expire = 1'b0;
`endif

    // State register plus the registered outputs that move with it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_trig    <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_hit_src <= '0;
            post_q    <= '0;
            mask_q    <= '0;
            mode_q    <= ANY;
        end else begin
            state     <= state_nx;
            o_trig    <= trig_nx;
            o_busy    <= (state_nx != IDLE);
            o_done    <= done_nx;
            o_hit_src <= hit_src_nx;
            if (arm_take) begin
                post_q <= i_post;
                mask_q <= i_src_mask;
                mode_q <= trig_mode_e'(i_mode);
            end
        end
    end

    // Next-state logic; abort overrides everything, including an IDLE arm
    always_comb begin
        state_nx = state;
        if (i_abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_arm) state_nx = (i_holdoff == '0) ? WAIT : HOLDOFF;
                HOLDOFF: if (hold_last) state_nx = WAIT;
                WAIT:    if (hit || expire) state_nx = FIRE;
                FIRE:    if (!sticky && post_last) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        trig_nx    = (state_nx == FIRE);
        done_nx    = (state == FIRE) && (state_nx == IDLE) && !i_abort;
        hit_src_nx = o_hit_src;
        if (fire_take) begin
            // A forced (timeout) fire reports no source
            hit_src_nx = hit ? (i_src & mask_q) : '0;
        end
    end

    assign o_state = state;

endmodule

// File: doc/dbg_trig_seq.md
# dbg_trig_seq

Programmable trigger sequencer for on-chip logic-analyzer capture. It is armed by software or a top-level strobe, then counts a holdoff delay. After the holdoff it waits for a masked combination of debug sources and drives the capture trigger for a programmed number of cycles, or sticky-high. It sits between the DCSK datapath debug taps and the Signal Tap trigger input, and replaces fixed-delay free-running triggers.

## Interface
Parameters:
- CTR_W, 27, width of holdoff, post and timeout counters
- N_SRC, 4, number of trigger source inputs
- TIMEOUT, 100000000, WAIT-state timeout in cycles (used only with macro)

Ports:
- i_clk  in  1  system clock; the only clock
- i_rst  in  1  synchronous, active-high reset
- i_arm  in  1  single-cycle arm request
- i_abort  in  1  single-cycle abort request
- i_holdoff  in  CTR_W  cycles to wait after arm before sources are evaluated
- i_post  in  CTR_W  trigger high duration in cycles; 0 = sticky
- i_src  in  N_SRC  raw trigger sources, already synchronous to i_clk
- i_src_mask  in  N_SRC  1 = source participates
- i_mode  in  1  0 = ANY (OR of masked sources), 1 = ALL (AND of masked sources)
- o_trig  out  1  registered trigger to capture logic
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse when a non-sticky fire completes
- o_state  out  2  current FSM state encoding
- o_hit_src  out  N_SRC  masked i_src value latched at the hit cycle

## Operation
- States: IDLE=0, HOLDOFF=1, WAIT=2, FIRE=3.
- Reset values: state IDLE, o_trig 0, o_busy 0, o_done 0, o_hit_src 0, all counters 0.
- IDLE: on i_arm, latch i_holdoff, i_post, i_src_mask and i_mode into shadow registers. Go to HOLDOFF, or go straight to WAIT if i_holdoff==0. Inputs are not resampled until the next arm.
- HOLDOFF: down-counter loaded with holdoff. Go to WAIT on the cycle the count reaches 1. Exactly H cycles are spent in HOLDOFF.
- WAIT: hit = (mask==0) ? 1 : (mode ? &(src|~mask) : |(src&mask)). A hit with mask==0 is an unconditional delayed trigger. On hit, latch o_hit_src = i_src & mask and go to FIRE.
- FIRE with post P>0: o_trig is high for exactly P cycles, then the block goes to IDLE with o_done pulsed on the first IDLE cycle.
- FIRE with P=0: o_trig stays high until abort or reset. o_done never pulses.
- i_abort in any non-IDLE state: IDLE next cycle, o_trig cleared, no o_done. o_hit_src is retained.
- i_arm while busy is ignored. i_arm and i_abort in the same IDLE cycle: abort wins, so the block stays IDLE.
- Counters are CTR_W-bit unsigned. Values up to 2^CTR_W-1 are legal and do not wrap.

## Timing
- Arm at cycle N, H>0: HOLDOFF occupies N+1..N+H and WAIT starts at N+H+1.
- Arm at cycle N, H=0: WAIT starts at N+1.
- Hit sampled combinationally in WAIT at cycle M: state FIRE and o_trig=1 at M+1. One cycle of latency.
- Non-sticky: o_trig high for M+1..M+P, o_trig low at M+P+1, and o_done=1 only at M+P+1.
- o_busy = (state != IDLE), registered with the state.
- Reset asserted mid-operation: all outputs take their reset values on the next edge.

## Configuration
- DBG_TRIG_TIMEOUT_EN defined: WAIT runs a TIMEOUT-cycle counter. If no hit occurs within TIMEOUT cycles, go to FIRE with o_hit_src=0, behaving as a forced trigger. A hit and expiry in the same cycle count as a hit.
- DBG_TRIG_TIMEOUT_EN undefined: WAIT holds indefinitely. The TIMEOUT parameter and its counter are not synthesized.

## Structure
- Package dbg_trig_pkg holds:
  - the trig_state_e enum (IDLE/HOLDOFF/WAIT/FIRE, 2 bits)
  - the trig_mode_e enum (ANY/ALL)
  - the localparam default CTR_W
- Sub-module dbg_trig_cnt is a loadable CTR_W down-counter with load, enable and a last (count==1) flag. It is instantiated for holdoff, post, and timeout (timeout only under the macro).

## Test plan
- Arm with H=5, P=3, mask=0: o_trig high exactly cycles 7..9 after arm, o_done at cycle 10, o_hit_src=0.
- Arm with H=0, mask=4'b0011, mode ANY; src[1] asserted 20 cycles later: o_trig rises 1 cycle after src[1], o_hit_src=4'b0010.
- Mode ALL, mask=4'b0101: src=4'b0001 gives no fire; src=4'b0101 fires next cycle. src=4'b1111 also fires, with o_hit_src=4'b0101.
- P=0 sticky: o_trig stays high for 1000 cycles with no o_done; i_abort clears o_trig next cycle and the state returns to IDLE.
- i_arm during HOLDOFF is ignored, with no change in timing. Same-cycle i_arm+i_abort in IDLE leaves the block IDLE. i_rst during FIRE drops o_trig on the next edge.
- DBG_TRIG_TIMEOUT_EN with TIMEOUT=50 and no source hit: FIRE is entered 50 cycles after entering WAIT, with o_hit_src=0.
